// File: rtl/mem_region_ctrl.sv
// mem_region_ctrl: word-addressed MIPS memory with text/data/stack regions behind a REQ/RDY/ACK handshake
//    i_clk         rising-edge clock
//    i_rst_n       asynchronous active-low reset
//    i_req         request valid; held by the requester until o_rdy
//    o_rdy         a request can be accepted this cycle
//    i_we          1 = write, 0 = read
//    i_be          byte enables, i_be[i] covers i_wd[8i+7:8i]
//    i_a           byte address
//    i_wd          write data
//    o_ack         one-cycle response strobe
//    o_rd          read data (holds until the next commit)
//    o_err         error response (holds until the next commit)
//    i_clr_fault   clears the sticky fault
//    o_fault       sticky fault flag
//    o_fault_addr  address of the first fault since the last clear
module mem_region_ctrl #(
   parameter logic [31:0] TEXT_BASE   = 32'h0000_0000,
   parameter int          TEXT_WORDS  = 256,
   parameter logic [31:0] DATA_BASE   = 32'h0000_0400,
   parameter int          DATA_WORDS  = 256,
   parameter logic [31:0] STACK_TOP   = 32'h7FFF_FFFC,
   parameter int          STACK_WORDS = 256,
   parameter int          LAT         = 1,
   parameter string       TEXT_INIT   = ""
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_req,
   output logic        o_rdy,
   input  logic        i_we,
   input  logic [3:0]  i_be,
   input  logic [31:0] i_a,
   input  logic [31:0] i_wd,
   output logic        o_ack,
   output logic [31:0] o_rd,
   output logic        o_err,
   input  logic        i_clr_fault,
   output logic        o_fault,
   output logic [31:0] o_fault_addr
);
   localparam int TW = $clog2(TEXT_WORDS);
   localparam int DW = $clog2(DATA_WORDS);
   localparam int SW = $clog2(STACK_WORDS);
   localparam logic [31:0] STACK_BASE = STACK_TOP - 32'(4 * (STACK_WORDS - 1));
   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
   state_t      r_state;
   logic [3:0]  r_cnt;
   logic        r_we;
   logic [3:0]  r_be;
   logic [31:0] r_a, r_wd, r_rd, r_fault_addr;
   logic        r_err, r_fault;
   logic [31:0] r_text  [TEXT_WORDS];
   logic [31:0] r_data  [DATA_WORDS];
   logic [31:0] r_stack [STACK_WORDS];
   logic        w_accept, w_direct, w_commit, w_we, w_mis, w_shit, w_thit, w_dhit, w_err;
   logic [3:0]  w_be;
   logic [31:0] w_a, w_wd, w_toff, w_doff, w_soff, w_rdata;
   logic [TW-1:0] w_tidx;
   logic [DW-1:0] w_didx;
   logic [SW-1:0] w_sidx;
   assign o_rdy    = r_state != BUSY;
   assign o_ack    = r_state == RESP;
   assign o_rd     = r_rd;
   assign o_err    = r_err;
   assign o_fault  = r_fault;
   assign o_fault_addr = r_fault_addr;
   assign w_accept = i_req && o_rdy;
   // With LAT=1 the accept edge is also the commit edge, so decode the live inputs.
   assign w_direct = w_accept && (LAT == 1);
   assign w_commit = w_direct || (r_state == BUSY && r_cnt == 4'd1);
   assign w_we     = w_direct ? i_we : r_we;
   assign w_be     = w_direct ? i_be : r_be;
   assign w_a      = w_direct ? i_a  : r_a;
   assign w_wd     = w_direct ? i_wd : r_wd;
   // Unsigned offsets wrap below the base, so one compare covers both bounds.
   assign w_toff   = w_a - TEXT_BASE;
   assign w_doff   = w_a - DATA_BASE;
   assign w_soff   = w_a - STACK_BASE;
   assign w_mis    = |w_a[1:0];
   assign w_shit   = !w_mis && w_soff < 32'(4 * STACK_WORDS);
   assign w_thit   = !w_mis && !w_shit && w_toff < 32'(4 * TEXT_WORDS);
   assign w_dhit   = !w_mis && !w_shit && !w_thit && w_doff < 32'(4 * DATA_WORDS);
   assign w_err    = !(w_shit || w_thit || w_dhit);
   assign w_tidx   = w_toff[TW+1:2];
   assign w_didx   = w_doff[DW+1:2];
   assign w_sidx   = w_soff[SW+1:2];
   assign w_rdata  = w_shit ? r_stack[w_sidx] : w_thit ? r_text[w_tidx] : w_dhit ? r_data[w_didx] : '0;
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= IDLE;
         r_cnt        <= '0;
         r_we         <= 1'b0;
         r_be         <= '0;
         r_a          <= '0;
         r_wd         <= '0;
         r_rd         <= '0;
         r_err        <= 1'b0;
         r_fault      <= 1'b0;
         r_fault_addr <= '0;
      end else begin
         if (w_accept) begin
            r_we  <= i_we;
            r_be  <= i_be;
            r_a   <= i_a;
            r_wd  <= i_wd;
            r_cnt <= 4'(LAT - 1);
         end else if (r_state == BUSY) begin
            r_cnt <= r_cnt - 4'd1;
         end
         r_state <= w_commit ? RESP : (w_accept || r_state == BUSY) ? BUSY : IDLE;
         if (w_commit) begin
            r_rd  <= (w_err || w_we) ? '0 : w_rdata;
            r_err <= w_err;
         end
         // A new fault on the clearing edge takes precedence over the clear.
         if (w_commit && w_err && (!r_fault || i_clr_fault)) begin
            r_fault      <= 1'b1;
            r_fault_addr <= w_a;
         end else if (i_clr_fault) begin
            r_fault      <= 1'b0;
            r_fault_addr <= '0;
         end
      end
   end
   // Arrays are never reset; a commit coinciding with reset is dropped.
   always_ff @(posedge i_clk) begin
      if (i_rst_n && w_commit && w_we && !w_err) begin
         for (int i = 0; i < 4; i++) begin
            if (w_be[i]) begin
               if (w_shit) r_stack[w_sidx][8*i +: 8] <= w_wd[8*i +: 8];
               else if (w_thit) r_text[w_tidx][8*i +: 8] <= w_wd[8*i +: 8];
               else r_data[w_didx][8*i +: 8] <= w_wd[8*i +: 8];
            end
         end
      end
   end
endmodule

// File: tb/tb_mem_region_ctrl.sv
// tb_mem_region_ctrl: directed checks of mem_region_ctrl at LAT=1 and LAT=3
module tb_mem_region_ctrl;
   logic        clk = 1'b0, rst_n = 1'b1, req1 = 1'b0, req3 = 1'b0, we = 1'b0, clr = 1'b0;
   logic [3:0]  be = '0;
   logic [31:0] a = '0, wd = '0;
   logic        rdy1, ack1, err1, fault1, rdy3, ack3, err3, fault3;
   logic [31:0] rd1, fa1, rd3, fa3;
   int          n_chk = 0, n_fail = 0;
   always #5 clk = ~clk;
   mem_region_ctrl #(.LAT(1)) u_dut1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_req(req1), .o_rdy(rdy1), .i_we(we), .i_be(be),
      .i_a(a), .i_wd(wd), .o_ack(ack1), .o_rd(rd1), .o_err(err1), .i_clr_fault(clr),
      .o_fault(fault1), .o_fault_addr(fa1));
   mem_region_ctrl #(.LAT(3)) u_dut3 (
      .i_clk(clk), .i_rst_n(rst_n), .i_req(req3), .o_rdy(rdy3), .i_we(we), .i_be(be),
      .i_a(a), .i_wd(wd), .o_ack(ack3), .o_rd(rd3), .o_err(err3), .i_clr_fault(clr),
      .o_fault(fault3), .o_fault_addr(fa3));
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   task automatic acc1(input logic w, input logic [3:0] b, input logic [31:0] ad, input logic [31:0] d);
      @(negedge clk);
      we = w; be = b; a = ad; wd = d; req1 = 1'b1;
      @(posedge clk);
      #1 req1 = 1'b0;
   endtask
   task automatic acc3(input string tag, input logic w, input logic [3:0] b, input logic [31:0] ad, input logic [31:0] d);
      int n;
      n = 0;
      @(negedge clk);
      we = w; be = b; a = ad; wd = d; req3 = 1'b1;
      @(posedge clk);
      #1 req3 = 1'b0;
      chk({tag, "_busy_rdy"}, 32'(rdy3), 32'd0);
      while (!ack3 && n < 10) begin
         @(posedge clk);
         #1 n++;
      end
      chk({tag, "_lat"}, n, 32'd2);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "timeout");
   end
   initial begin
      int acks;
      #1 rst_n = 1'b0;
      #2;
      chk("rst_rdy", 32'(rdy1), 32'd1);
      chk("rst_ack", 32'(ack1), 32'd0);
      chk("rst_rd", rd1, 32'd0);
      chk("rst_fault", 32'(fault1), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      acc1(1'b1, 4'hF, 32'h0000_0404, 32'hCAFE_F00D);
      chk("w404_ack", 32'(ack1), 32'd1);
      chk("w404_err", 32'(err1), 32'd0);
      chk("w404_rd", rd1, 32'd0);
      acc1(1'b0, 4'h0, 32'h0000_0404, 32'h0);
      chk("r404_ack", 32'(ack1), 32'd1);
      chk("r404_rd", rd1, 32'hCAFE_F00D);
      chk("r404_err", 32'(err1), 32'd0);
      @(posedge clk);
      #1;
      chk("hold_ack", 32'(ack1), 32'd0);
      chk("hold_rd", rd1, 32'hCAFE_F00D);
      acc1(1'b1, 4'hF, 32'h7FFF_FFFC, 32'h1122_3344);
      acc1(1'b1, 4'b0101, 32'h7FFF_FFFC, 32'hAABB_CCDD);
      acc1(1'b0, 4'h0, 32'h7FFF_FFFC, 32'h0);
      chk("be_rd", rd1, 32'h11BB_33DD);
      acc1(1'b1, 4'h0, 32'h7FFF_FFFC, 32'hFFFF_FFFF);
      chk("nop_err", 32'(err1), 32'd0);
      acc1(1'b0, 4'h0, 32'h7FFF_FFFC, 32'h0);
      chk("nop_rd", rd1, 32'h11BB_33DD);
      acc1(1'b0, 4'h0, 32'h0000_0406, 32'h0);
      chk("mis_ack", 32'(ack1), 32'd1);
      chk("mis_err", 32'(err1), 32'd1);
      chk("mis_rd", rd1, 32'd0);
      chk("mis_fault", 32'(fault1), 32'd1);
      chk("mis_faddr", fa1, 32'h0000_0406);
      acc1(1'b1, 4'hF, 32'h1000_0000, 32'hFFFF_FFFF);
      chk("unm_err", 32'(err1), 32'd1);
      chk("unm_faddr", fa1, 32'h0000_0406);
      acc1(1'b0, 4'h0, 32'h0000_0404, 32'h0);
      chk("unm_keep", rd1, 32'hCAFE_F00D);
      chk("unm_keep_err", 32'(err1), 32'd0);
      acc1(1'b0, 4'h0, 32'h7FFF_FFFC, 32'h0);
      chk("unm_keep_stk", rd1, 32'h11BB_33DD);
      @(negedge clk) clr = 1'b1;
      @(posedge clk);
      #1 clr = 1'b0;
      chk("clr_fault", 32'(fault1), 32'd0);
      chk("clr_faddr", fa1, 32'd0);
      acc1(1'b1, 4'hF, 32'h7FFF_FC00, 32'h5A5A_5A5A);
      chk("sbase_err", 32'(err1), 32'd0);
      acc1(1'b1, 4'hF, 32'h0000_07FC, 32'h0D0D_07FC);
      chk("dlast_err", 32'(err1), 32'd0);
      acc1(1'b1, 4'hF, 32'h0000_03FC, 32'h7E57_03FC);
      acc1(1'b0, 4'h0, 32'h7FFF_FC00, 32'h0);
      chk("sbase_rd", rd1, 32'h5A5A_5A5A);
      acc1(1'b0, 4'h0, 32'h0000_07FC, 32'h0);
      chk("dlast_rd", rd1, 32'h0D0D_07FC);
      acc1(1'b0, 4'h0, 32'h0000_03FC, 32'h0);
      chk("tlast_rd", rd1, 32'h7E57_03FC);
      acc1(1'b0, 4'h0, 32'h0000_0800, 32'h0);
      chk("dend_err", 32'(err1), 32'd1);
      chk("dend_faddr", fa1, 32'h0000_0800);
      acc1(1'b0, 4'h0, 32'h7FFF_FBFC, 32'h0);
      chk("sbelow_err", 32'(err1), 32'd1);
      chk("sbelow_faddr", fa1, 32'h0000_0800);
      @(negedge clk);
      we = 1'b0; a = 32'h0000_0406; clr = 1'b1; req1 = 1'b1;
      @(posedge clk);
      #1 clr = 1'b0; req1 = 1'b0;
      chk("clrerr_fault", 32'(fault1), 32'd1);
      chk("clrerr_faddr", fa1, 32'h0000_0406);
      acc3("w0", 1'b1, 4'hF, 32'h0, 32'h1111_0000);
      acc3("w4", 1'b1, 4'hF, 32'h4, 32'h2222_0004);
      acc3("w400", 1'b1, 4'hF, 32'h400, 32'h0BAD_0400);
      @(negedge clk);
      we = 1'b0; a = 32'h0; req3 = 1'b1;
      @(posedge clk);
      #1 a = 32'h4;
      chk("b2b_rdy_a", 32'(rdy3), 32'd0);
      @(posedge clk);
      #1;
      chk("b2b_rdy_b", 32'(rdy3), 32'd0);
      chk("b2b_ack_b", 32'(ack3), 32'd0);
      @(posedge clk);
      #1;
      chk("b2b_ack0", 32'(ack3), 32'd1);
      chk("b2b_rd0", rd3, 32'h1111_0000);
      chk("b2b_rdy0", 32'(rdy3), 32'd1);
      @(posedge clk);
      #1;
      chk("b2b_rdy_c", 32'(rdy3), 32'd0);
      @(posedge clk);
      #1;
      chk("b2b_rdy_d", 32'(rdy3), 32'd0);
      @(posedge clk);
      #1;
      chk("b2b_ack4", 32'(ack3), 32'd1);
      chk("b2b_rd4", rd3, 32'h2222_0004);
      req3 = 1'b0;
      @(posedge clk);
      #1;
      chk("b2b_idle_ack", 32'(ack3), 32'd0);
      chk("b2b_idle_rdy", 32'(rdy3), 32'd1);
      @(negedge clk);
      we = 1'b1; be = 4'hF; a = 32'h400; wd = 32'hDEAD_BEEF; req3 = 1'b1;
      @(posedge clk);
      #1 req3 = 1'b0;
      chk("flight_rdy", 32'(rdy3), 32'd0);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mrst_rdy", 32'(rdy3), 32'd1);
      chk("mrst_ack", 32'(ack3), 32'd0);
      chk("mrst_rd", rd3, 32'd0);
      chk("mrst_fault", 32'(fault1), 32'd0);
      chk("mrst_faddr", fa1, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      acks = 0;
      repeat (4) begin
         @(posedge clk);
         #1 acks += int'(ack3);
      end
      chk("mrst_noack", acks, 32'd0);
      acc3("r400", 1'b0, 4'h0, 32'h400, 32'h0);
      chk("mrst_old", rd3, 32'h0BAD_0400);
      chk("mrst_old_err", 32'(err3), 32'd0);
      acc1(1'b0, 4'h0, 32'h0000_0404, 32'h0);
      chk("mrst_keep", rd1, 32'hCAFE_F00D);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
